// File: rtl/softmax_sched_pkg.sv
// softmax_pkg: shared definitions for the softmax scheduler slice.
//   state_t   - controller states
//   FP_ZERO   - IEEE-754 single +0.0, used to seed the exponent sum
//   INPUT_NUM - softmax vector length
//   idx_width - width of an element index for a vector of n elements
package softmax_pkg;

    typedef enum logic [2:0] {
        IDLE,
        EXP_RUN,
        EXP_GAP,
        REC_RUN,
        MUL,
        DONE
    } state_t;

    localparam logic [31:0] FP_ZERO = 32'h00000000;
    localparam int INPUT_NUM = 10;

    // Never narrower than one bit, so a single-element vector still gets an index.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/softmax_sched_if.sv
// softmax_sched_if: start/done handshake, operand/result vectors and the
// ports towards the shared exponent, adder, reciprocal and multiplier units.
//   master - the scheduler: takes start/inputs and unit results, drives
//            status, the result vector and every unit operand/enable
//   slave  - the surrounding system: the mirror image of master
interface softmax_sched_if
    import softmax_pkg::*;
#(
    parameter int DATA_WIDTH = 32
);
    localparam int VEC_WIDTH = DATA_WIDTH * INPUT_NUM;

    logic                  start;
    logic [VEC_WIDTH-1:0]  inputs;
    logic                  busy;
    logic                  done;
    logic                  err;
    logic [VEC_WIDTH-1:0]  outputs;

    logic [DATA_WIDTH-1:0] exp_x;
    logic                  exp_enable;
    logic [DATA_WIDTH-1:0] exp_result;
    logic                  exp_ack;

    logic [DATA_WIDTH-1:0] add_a;
    logic [DATA_WIDTH-1:0] add_b;
    logic [DATA_WIDTH-1:0] add_sum;

    logic [DATA_WIDTH-1:0] rec_number;
    logic                  rec_enable;
    logic [DATA_WIDTH-1:0] rec_result;
    logic                  rec_ack;

    logic [DATA_WIDTH-1:0] mul_a;
    logic [DATA_WIDTH-1:0] mul_b;
    logic [DATA_WIDTH-1:0] mul_result;

    modport master (
        input  start, inputs, exp_result, exp_ack, add_sum, rec_result, rec_ack, mul_result,
        output busy, done, err, outputs, exp_x, exp_enable, add_a, add_b,
               rec_number, rec_enable, mul_a, mul_b
    );

    modport slave (
        output start, inputs, exp_result, exp_ack, add_sum, rec_result, rec_ack, mul_result,
        input  busy, done, err, outputs, exp_x, exp_enable, add_a, add_b,
               rec_number, rec_enable, mul_a, mul_b
    );

endinterface

// File: rtl/softmax_sched_ack_watchdog.sv
// ack_watchdog: times one wait on a shared unit's acknowledge.
//   clk, reset - clock and synchronous active-high reset
//   run        - high while the controller stays in the same wait state;
//                low clears the count (so every state change restarts it)
//   ack        - raw acknowledge from the unit being waited on
//   ack_ok     - ack qualified: ignored in the first cycle of a wait, since
//                the unit may still be presenting an ack from its last job
//   timeout    - the wait has lasted TIMEOUT cycles beyond its first
module ack_watchdog #(
    parameter int TIMEOUT = 1023
) (
    input  logic clk,
    input  logic reset,
    input  logic run,
    input  logic ack,
    output logic ack_ok,
    output logic timeout
);
    localparam int CW = $clog2(TIMEOUT + 1);

    logic [CW-1:0] count;

    // The controller leaves the wait state on timeout, so the count never
    // has to saturate.
    always_ff @(posedge clk) begin
        if (reset || !run) begin
            count <= '0;
        end else begin
            count <= count + 1'b1;
        end
    end

    assign ack_ok  = ack && (count != '0);
    assign timeout = (count == CW'(TIMEOUT));

endmodule

// File: rtl/softmax_sched.sv
// softmax_sched: time-multiplexed 10-way softmax controller. Exponentiates
// each input through one shared exponent unit, accumulates the exponents
// through the shared adder, takes one reciprocal of the sum and scales every
// buffered exponent by it through the shared multiplier.
//   clk, reset - clock and synchronous active-high reset
//   bus        - softmax_sched_if.master: start/busy/done/err handshake,
//                input/result vectors and the shared-unit ports
module softmax_sched
    import softmax_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int TIMEOUT    = 1023
) (
    input  logic             clk,
    input  logic             reset,
    softmax_sched_if.master  bus
);
    localparam int IDX_W = idx_width(INPUT_NUM);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(INPUT_NUM - 1);

    state_t                        state;
    state_t                        state_next;
    logic [IDX_W-1:0]              idx;
    logic [DATA_WIDTH-1:0]         sum;
    logic [DATA_WIDTH-1:0]         rec;
    logic [DATA_WIDTH-1:0]         exp_buf [INPUT_NUM];
    logic [DATA_WIDTH*INPUT_NUM-1:0] out_vec;
    logic                          err;

    logic                          waiting;
    logic                          hold_state;
    logic                          unit_ack;
    logic                          ack_ok;
    logic                          timeout;
    logic                          abort;

    logic [DATA_WIDTH-1:0]         exp_x;
    logic                          exp_enable;
    logic [DATA_WIDTH-1:0]         add_a;
    logic [DATA_WIDTH-1:0]         add_b;
    logic [DATA_WIDTH-1:0]         rec_number;
    logic                          rec_enable;
    logic [DATA_WIDTH-1:0]         mul_a;
    logic [DATA_WIDTH-1:0]         mul_b;

    // Only one unit is ever waited on at a time, so one watchdog serves both.
    assign waiting    = (state == EXP_RUN) || (state == REC_RUN);
    assign unit_ack   = (state == EXP_RUN) ? bus.exp_ack : bus.rec_ack;
    assign hold_state = waiting && (state_next == state);
    assign abort      = waiting && timeout && !ack_ok;

    ack_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_watchdog (
        .clk     (clk),
        .reset   (reset),
        .run     (hold_state),
        .ack     (unit_ack),
        .ack_ok  (ack_ok),
        .timeout (timeout)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // An ack that lands together with the timeout still counts as success.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (bus.start) state_next = EXP_RUN;
            EXP_RUN: begin
                if (ack_ok)       state_next = EXP_GAP;
                else if (timeout) state_next = DONE;
            end
            EXP_GAP: state_next = (idx < LAST_IDX) ? EXP_RUN : REC_RUN;
            REC_RUN: begin
                if (ack_ok)       state_next = MUL;
                else if (timeout) state_next = DONE;
            end
            MUL:     if (idx == LAST_IDX) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Unit operands are only non-zero while that unit is in use, and the
    // enables fall in the same cycle the watchdog gives up.
    always_comb begin
        exp_x      = '0;
        exp_enable = 1'b0;
        add_a      = '0;
        add_b      = '0;
        rec_number = '0;
        rec_enable = 1'b0;
        mul_a      = '0;
        mul_b      = '0;
        case (state)
            EXP_RUN: begin
                exp_enable = !abort;
                exp_x      = bus.inputs[int'(idx)*DATA_WIDTH +: DATA_WIDTH];
                add_a      = bus.exp_result;
                add_b      = sum;
            end
            REC_RUN: begin
                rec_enable = !abort;
                rec_number = sum;
            end
            MUL: begin
                mul_a = exp_buf[idx];
                mul_b = rec;
            end
            default: ;
        endcase
    end

    // Results and err survive until the next accepted start, which is where
    // the previous run's state is wiped.
    always_ff @(posedge clk) begin
        if (reset) begin
            idx     <= '0;
            sum     <= DATA_WIDTH'(FP_ZERO);
            rec     <= '0;
            err     <= 1'b0;
            out_vec <= '0;
            for (int i = 0; i < INPUT_NUM; i++) begin
                exp_buf[i] <= '0;
            end
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        idx     <= '0;
                        sum     <= DATA_WIDTH'(FP_ZERO);
                        rec     <= '0;
                        err     <= 1'b0;
                        out_vec <= '0;
                    end
                end
                EXP_RUN: begin
                    if (ack_ok) begin
                        exp_buf[idx] <= bus.exp_result;
                        sum          <= bus.add_sum;
                    end else if (abort) begin
                        err <= 1'b1;
                    end
                end
                EXP_GAP: idx <= (idx < LAST_IDX) ? idx + 1'b1 : '0;
                REC_RUN: begin
                    if (ack_ok) begin
                        rec <= bus.rec_result;
                    end else if (abort) begin
                        err <= 1'b1;
                    end
                end
                MUL: begin
                    out_vec[int'(idx)*DATA_WIDTH +: DATA_WIDTH] <= bus.mul_result;
                    idx <= (idx == LAST_IDX) ? '0 : idx + 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign bus.busy       = (state != IDLE);
    assign bus.done       = (state == DONE);
    assign bus.err        = err;
    assign bus.outputs    = out_vec;
    assign bus.exp_x      = exp_x;
    assign bus.exp_enable = exp_enable;
    assign bus.add_a      = add_a;
    assign bus.add_b      = add_b;
    assign bus.rec_number = rec_number;
    assign bus.rec_enable = rec_enable;
    assign bus.mul_a      = mul_a;
    assign bus.mul_b      = mul_b;

endmodule

// File: tb/tb_softmax_sched.sv
// tb_softmax_sched: directed bench for softmax_sched. dut0 uses the default
// watchdog limit; dut1 uses TIMEOUT=8 with a reciprocal unit that never acks.
// Exponent/reciprocal units are latency-programmable stubs; the adder and
// multiplier are real single-precision arithmetic (exact for these values).
module tb_softmax_sched;
    import softmax_pkg::*;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    softmax_sched_if #(.DATA_WIDTH(32)) bus0 ();
    softmax_sched_if #(.DATA_WIDTH(32)) bus1 ();

    softmax_sched #(.DATA_WIDTH(32), .TIMEOUT(1023)) dut0 (.clk(clk), .reset(reset), .bus(bus0));
    softmax_sched #(.DATA_WIDTH(32), .TIMEOUT(8))    dut1 (.clk(clk), .reset(reset), .bus(bus1));

    int checks = 0;
    int errors = 0;

    // Stub configuration: ack in the le-th / lr-th cycle of each enable burst.
    int          le = 4;
    int          lr = 6;
    bit          exp_stale = 1'b0;
    bit          exp_identity = 1'b0;
    logic [31:0] rec_value = 32'h3DCCCCCD;
    int          e_cnt0 = 0;
    int          r_cnt0 = 0;
    int          e_cnt1 = 0;

    // Run monitors.
    int          k;
    int          done_count;
    int          lat1;
    int          lat2;
    int          exp_runs;
    int          exp_high;
    int          max_gap;
    int          gap_cur;
    logic        prev_en;
    logic        busy_first;
    logic [31:0] obs_sum;
    logic [31:0] want [INPUT_NUM];
    logic [31:0] in_tab [INPUT_NUM];

    function automatic real f2r(input logic [31:0] f);
        logic [10:0] e;
        if (f[30:0] == 31'd0) return 0.0;
        e = 11'(f[30:23]) + 11'd896;
        return $bitstoreal({f[31], e, f[22:0], 29'd0});
    endfunction

    function automatic logic [31:0] r2f(input real r);
        logic [63:0] b;
        logic [10:0] e;
        b = $realtobits(r);
        if (b[62:0] == 63'd0) return 32'd0;
        e = b[62:52] - 11'd896;
        return {b[63], e[7:0], b[51:29]};
    endfunction

    always @(posedge clk) begin
        e_cnt0 <= bus0.exp_enable ? e_cnt0 + 1 : 0;
        r_cnt0 <= bus0.rec_enable ? r_cnt0 + 1 : 0;
        e_cnt1 <= bus1.exp_enable ? e_cnt1 + 1 : 0;
    end

    assign bus0.exp_ack    = exp_stale || (bus0.exp_enable && (e_cnt0 == le - 1));
    assign bus0.exp_result = exp_identity ? bus0.exp_x : 32'h3F800000;
    assign bus0.rec_ack    = bus0.rec_enable && (r_cnt0 == lr - 1);
    assign bus0.rec_result = rec_value;
    assign bus0.add_sum    = r2f(f2r(bus0.add_a) + f2r(bus0.add_b));
    assign bus0.mul_result = r2f(f2r(bus0.mul_a) * f2r(bus0.mul_b));

    assign bus1.exp_ack    = bus1.exp_enable && (e_cnt1 == le - 1);
    assign bus1.exp_result = 32'h3F800000;
    assign bus1.rec_ack    = 1'b0;
    assign bus1.rec_result = 32'h0;
    assign bus1.add_sum    = r2f(f2r(bus1.add_a) + f2r(bus1.add_b));
    assign bus1.mul_result = r2f(f2r(bus1.mul_a) * f2r(bus1.mul_b));

    task automatic check_output(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic check_vector(input string tag, input logic [32*INPUT_NUM-1:0] vec);
        for (int i = 0; i < INPUT_NUM; i++) begin
            check_output($sformatf("%s[%0d]", tag, i), vec[i*32 +: 32], want[i]);
        end
    endtask

    task automatic fill_want(input logic [31:0] value);
        for (int i = 0; i < INPUT_NUM; i++) want[i] = value;
    endtask

    task automatic set_inputs0(input bit use_table);
        for (int i = 0; i < INPUT_NUM; i++) bus0.inputs[i*32 +: 32] = use_table ? in_tab[i] : 32'h0;
    endtask

    // One run on dut0 starting from IDLE; hold keeps start high for two runs.
    task automatic apply_stimulus(input bit hold, input int pulse_at);
        int needed;
        needed = hold ? 2 : 1;
        @(negedge clk);
        k = 0; done_count = 0; lat1 = -1; lat2 = -1;
        exp_runs = 0; exp_high = 0; max_gap = 0; gap_cur = 0; prev_en = 1'b0;
        obs_sum = 32'hXXXXXXXX; busy_first = 1'b0;
        bus0.start = 1'b1;
        while (done_count < needed && k < 400) begin
            @(negedge clk);
            k++;
            if (k == 1) busy_first = bus0.busy;
            if (bus0.exp_enable) begin
                exp_high++;
                if (!prev_en) begin
                    if (exp_runs > 0 && gap_cur > max_gap) max_gap = gap_cur;
                    exp_runs++;
                    gap_cur = 0;
                end
            end else if (exp_runs > 0) begin
                gap_cur++;
            end
            prev_en = bus0.exp_enable;
            if (bus0.rec_enable) obs_sum = bus0.rec_number;
            if (bus0.done) begin
                done_count++;
                if (done_count == 1) lat1 = k;
                else lat2 = k;
            end
            bus0.start = (hold && done_count < needed) || (k == pulse_at);
        end
        bus0.start = 1'b0;
    endtask

    initial begin
        in_tab = '{32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000, 32'h40A00000,
                   32'h40C00000, 32'h40E00000, 32'h41000000, 32'h41100000, 32'h41200000};
        reset = 1'b1;
        bus0.start = 1'b0;
        bus1.start = 1'b0;
        bus1.inputs = '0;
        set_inputs0(1'b1);
        repeat (3) @(negedge clk);

        $display("[TB] reset state");
        check_output("rst_busy", 32'(bus0.busy), 32'd0);
        check_output("rst_done", 32'(bus0.done), 32'd0);
        check_output("rst_err", 32'(bus0.err), 32'd0);
        check_output("rst_exp_en", 32'(bus0.exp_enable), 32'd0);
        check_output("rst_rec_en", 32'(bus0.rec_enable), 32'd0);
        check_output("rst_exp_x", bus0.exp_x, 32'd0);
        check_output("rst_mul_a", bus0.mul_a, 32'd0);
        fill_want(32'h0);
        check_vector("rst_out", bus0.outputs);
        reset = 1'b0;

        $display("[TB] all-zero inputs, Le=4 Lr=6");
        set_inputs0(1'b0);
        apply_stimulus(1'b0, 0);
        check_output("t1_busy_rise", 32'(busy_first), 32'd1);
        check_output("t1_latency", 32'(lat1), 32'd67);
        check_output("t1_sum", obs_sum, 32'h41200000);
        check_output("t1_exp_runs", 32'(exp_runs), 32'd10);
        check_output("t1_exp_high", 32'(exp_high), 32'd40);
        check_output("t1_err", 32'(bus0.err), 32'd0);
        fill_want(32'h3DCCCCCD);
        check_vector("t1_out", bus0.outputs);
        @(negedge clk);
        check_output("t1_busy_fall", 32'(bus0.busy), 32'd0);
        check_output("t1_done_pulse", 32'(bus0.done), 32'd0);
        check_vector("t1_out_held", bus0.outputs);

        $display("[TB] distinct exponents, Le=3 Lr=2, start pulsed while busy");
        set_inputs0(1'b1);
        exp_identity = 1'b1; le = 3; lr = 2; rec_value = 32'h3F000000;
        apply_stimulus(1'b0, 20);
        check_output("t2_latency", 32'(lat1), 32'd53);
        check_output("t2_sum", obs_sum, 32'h425C0000);
        want = '{32'h3F000000, 32'h3F800000, 32'h3FC00000, 32'h40000000, 32'h40200000,
                 32'h40400000, 32'h40600000, 32'h40800000, 32'h40900000, 32'h40A00000};
        check_vector("t2_out", bus0.outputs);
        @(negedge clk);
        check_output("t2_no_restart", 32'(bus0.busy), 32'd0);

        $display("[TB] exponent ack stuck high");
        set_inputs0(1'b0);
        exp_identity = 1'b0; exp_stale = 1'b1; lr = 6; rec_value = 32'h3DCCCCCD;
        apply_stimulus(1'b0, 0);
        exp_stale = 1'b0;
        check_output("t3_latency", 32'(lat1), 32'd47);
        check_output("t3_exp_runs", 32'(exp_runs), 32'd10);
        check_output("t3_exp_high", 32'(exp_high), 32'd20);
        check_output("t3_gap", 32'(max_gap), 32'd1);
        check_output("t3_sum", obs_sum, 32'h41200000);
        fill_want(32'h3DCCCCCD);
        check_vector("t3_out", bus0.outputs);

        $display("[TB] reset during exponent phase at element 5");
        set_inputs0(1'b1);
        exp_identity = 1'b1; le = 4; lr = 2; rec_value = 32'h3F000000;
        @(negedge clk);
        bus0.start = 1'b1;
        @(negedge clk);
        bus0.start = 1'b0;
        k = 0;
        while (!(bus0.exp_enable && bus0.exp_x === 32'h40C00000) && k < 200) begin
            @(negedge clk);
            k++;
        end
        check_output("t4_reach_idx5", bus0.exp_x, 32'h40C00000);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check_output("t4_busy", 32'(bus0.busy), 32'd0);
        check_output("t4_exp_en", 32'(bus0.exp_enable), 32'd0);
        fill_want(32'h0);
        check_vector("t4_out", bus0.outputs);
        apply_stimulus(1'b0, 0);
        check_output("t4_rerun_latency", 32'(lat1), 32'd63);
        check_output("t4_rerun_sum", obs_sum, 32'h425C0000);
        want = '{32'h3F000000, 32'h3F800000, 32'h3FC00000, 32'h40000000, 32'h40200000,
                 32'h40400000, 32'h40600000, 32'h40800000, 32'h40900000, 32'h40A00000};
        check_vector("t4_rerun_out", bus0.outputs);

        $display("[TB] back-to-back runs with start held");
        set_inputs0(1'b0);
        exp_identity = 1'b0; le = 4; lr = 6; rec_value = 32'h3DCCCCCD;
        apply_stimulus(1'b1, 0);
        check_output("t5_first_latency", 32'(lat1), 32'd67);
        check_output("t5_spacing", 32'(lat2 - lat1), 32'd68);
        fill_want(32'h3DCCCCCD);
        check_vector("t5_out", bus0.outputs);

        $display("[TB] reciprocal timeout, TIMEOUT=8");
        @(negedge clk);
        bus1.start = 1'b1;
        @(negedge clk);
        bus1.start = 1'b0;
        k = 1;
        while (!bus1.done && k < 300) begin
            @(negedge clk);
            k++;
        end
        check_output("t6_done", 32'(bus1.done), 32'd1);
        check_output("t6_err", 32'(bus1.err), 32'd1);
        check_output("t6_rec_en", 32'(bus1.rec_enable), 32'd0);
        fill_want(32'h0);
        check_vector("t6_out", bus1.outputs);
        @(negedge clk);
        check_output("t6_busy_after", 32'(bus1.busy), 32'd0);
        check_output("t6_err_held", 32'(bus1.err), 32'd1);
        bus1.start = 1'b1;
        @(negedge clk);
        bus1.start = 1'b0;
        check_output("t6_err_cleared", 32'(bus1.err), 32'd0);
        check_output("t6_busy_restart", 32'(bus1.busy), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL global_timeout observed=stuck expected=finish");
        $fatal(1, "[TB] simulation time limit exceeded");
    end

endmodule
